atm_pin_entry: RTL and testbench

//  Upstream stage of the ATM control FSM: collects keypad digits after card insertion, compares them

---
 rtl/atm_pin_entry.sv | 150 +++++++++++++++
 tb/tb_atm_pin_entry.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_entry.sv
// ============================================================================
// atm_pin_entry: keypad PIN collection, compare, try counting and card lockout.
// Optional PIN_TIMEOUT_EN adds an ENTRY inactivity timeout.   Rev 1.0
// ============================================================================
`default_nettype none

module atm_pin_entry #(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 3
`ifdef PIN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         card_inserted,
  input  logic [4*DIGITS-1:0]          ref_pin,
  input  logic                         key_valid,
  input  logic [3:0]                   key_digit,
  input  logic                         key_enter,
  input  logic                         key_clear,
  output logic                         pin_correct,
  output logic                         pin_fail,
  output logic                         card_retained,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic [2:0]                   tries_left,
  output logic                         timeout
);

  localparam int              CW         = $clog2(DIGITS+1);
  localparam logic [CW-1:0]   FULL       = CW'(DIGITS);
  localparam logic [2:0]      TRIES_INIT = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    COMPARE = 3'd2,
    PASS    = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] entry;
  logic                match;
  logic                idle_expired;
  logic                fail_now;

  assign match    = (digit_count == FULL) && (entry == ref_pin);
  assign fail_now = card_inserted &&
                    (((state == COMPARE) && !match) || idle_expired);

`ifdef PIN_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Any key strobe counts as activity, even a digit that is later dropped.
  assign idle_expired = (state == ENTRY) && card_inserted &&
                        !(key_valid || key_enter || key_clear) &&
                        (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (state != ENTRY) || key_valid || key_enter || key_clear || idle_expired)
      idle_cnt <= 32'd0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`else
  assign idle_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      entry         <= '0;
      pin_correct   <= 1'b0;
      pin_fail      <= 1'b0;
      card_retained <= 1'b0;
      digit_count   <= '0;
      tries_left    <= TRIES_INIT;
      timeout       <= 1'b0;
    end else begin
      pin_fail <= 1'b0;
      timeout  <= idle_expired;
      case (state)
        IDLE: begin
          if (card_inserted) begin
            state       <= ENTRY;
            entry       <= '0;
            digit_count <= '0;
            tries_left  <= TRIES_INIT;
          end
        end
        ENTRY, COMPARE: begin
          if (!card_inserted) begin
            state       <= IDLE;
            entry       <= '0;
            digit_count <= '0;
            tries_left  <= TRIES_INIT;
          end else if (state == COMPARE) begin
            if (match) begin
              state       <= PASS;
              pin_correct <= 1'b1;
            end
          end else if (!idle_expired) begin
            if (key_clear) begin
              entry       <= '0;
              digit_count <= '0;
            end else if (key_enter) begin
              state <= COMPARE;
            end else if (key_valid && (key_digit <= 4'd9) && (digit_count < FULL)) begin
              entry       <= {entry[4*DIGITS-5:0], key_digit};
              digit_count <= digit_count + 1'b1;
            end
          end
        end
        PASS: begin
          if (!card_inserted) begin
            state       <= IDLE;
            pin_correct <= 1'b0;
            entry       <= '0;
            digit_count <= '0;
            tries_left  <= TRIES_INIT;
          end
        end
        LOCKED: begin
          card_retained <= 1'b1;
          pin_correct   <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // A rejected attempt (wrong PIN or inactivity) overrides the case defaults.
      if (fail_now) begin
        pin_fail    <= 1'b1;
        entry       <= '0;
        digit_count <= '0;
        tries_left  <= tries_left - 3'd1;
        if (tries_left <= 3'd1) begin
          state         <= LOCKED;
          card_retained <= 1'b1;
        end else begin
          state <= ENTRY;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_atm_pin_entry.sv
// ============================================================================
// tb_atm_pin_entry: table-driven checks of atm_pin_entry plus an inactivity run.
// ============================================================================
`default_nettype none

module tb_atm_pin_entry;

  logic        clk = 1'b0;
  logic        rst, card_inserted, key_valid, key_enter, key_clear;
  logic [15:0] ref_pin;
  logic [3:0]  key_digit;
  logic        pin_correct, pin_fail, card_retained, timeout;
  logic [2:0]  digit_count, tries_left;

  int n_checks = 0;
  int n_pass   = 0;

  atm_pin_entry #(
    .DIGITS(4),
    .MAX_TRIES(3)
`ifdef PIN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .card_inserted(card_inserted), .ref_pin(ref_pin),
    .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
    .key_clear(key_clear), .pin_correct(pin_correct), .pin_fail(pin_fail),
    .card_retained(card_retained), .digit_count(digit_count),
    .tries_left(tries_left), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       card, kv;
    logic [3:0] d;
    logic       ke, kc, rs;
    logic       pc, pf, cr;
    logic [2:0] cnt, tl;
    logic       cnt_dc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, int kv, int d, int ke, int kc, int rs,
                              int pc, int pf, int cr, int cnt, int tl, int dc);
    vec_t v;
    v.card = c[0]; v.kv = kv[0]; v.d = d[3:0]; v.ke = ke[0]; v.kc = kc[0]; v.rs = rs[0];
    v.pc = pc[0]; v.pf = pf[0]; v.cr = cr[0]; v.cnt = cnt[2:0]; v.tl = tl[2:0];
    v.cnt_dc = dc[0];
    return v;
  endfunction

  // Card present, one digit key, outputs otherwise quiet.
  function automatic vec_t kd(int d, int cnt, int tl);
    return mk(1, 1, d, 0, 0, 0, 0, 0, 0, cnt, tl, 0);
  endfunction

  // Card present, no keys.
  function automatic vec_t idle(int pc, int pf, int cr, int cnt, int tl);
    return mk(1, 0, 0, 0, 0, 0, pc, pf, cr, cnt, tl, 0);
  endfunction

  task automatic check(input string name, input int row, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
  endtask

  task automatic step(input logic c, input logic kv, input logic [3:0] d,
                      input logic ke, input logic kc, input logic rs);
    card_inserted = c; key_valid = kv; key_digit = d;
    key_enter = ke; key_clear = kc; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_to, to_count, fail_with, tries_at;
    ref_pin = 16'h1234;
    rst = 1'b1; card_inserted = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    key_enter = 1'b0; key_clear = 1'b0;

    // reset, correct PIN, keys ignored in PASS
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,3,0));
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(1,1,3)); vecs.push_back(kd(2,2,3));
    vecs.push_back(kd(3,3,3)); vecs.push_back(kd(4,4,3));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,4,3,0));
    vecs.push_back(idle(1,0,0,4,3));
    vecs.push_back(mk(1,1,5,1,1,0, 1,0,0,4,3,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,3,1));
    // clear wins over enter, invalid and surplus digits dropped
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(1,1,3)); vecs.push_back(kd(2,2,3));
    vecs.push_back(mk(1,0,0,1,1,0, 0,0,0,0,3,0));
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(1,1,3)); vecs.push_back(kd(2,2,3)); vecs.push_back(kd(12,2,3));
    vecs.push_back(kd(3,3,3)); vecs.push_back(kd(4,4,3)); vecs.push_back(kd(5,4,3));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,4,3,0));
    vecs.push_back(idle(1,0,0,4,3));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,3,1));
    // short PIN, then two wrong PINs -> lockout
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(1,1,3)); vecs.push_back(kd(2,2,3)); vecs.push_back(kd(3,3,3));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,3,3,0));
    vecs.push_back(idle(0,1,0,0,2));
    vecs.push_back(idle(0,0,0,0,2));
    vecs.push_back(kd(1,1,2)); vecs.push_back(kd(2,2,2));
    vecs.push_back(kd(3,3,2)); vecs.push_back(kd(5,4,2));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,4,2,0));
    vecs.push_back(idle(0,1,0,0,1));
    vecs.push_back(kd(1,1,1)); vecs.push_back(kd(2,2,1));
    vecs.push_back(kd(3,3,1)); vecs.push_back(kd(5,4,1));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,4,1,0));
    vecs.push_back(idle(0,1,1,0,0));
    vecs.push_back(idle(0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,0,0,0,3,0));
    // removal with simultaneous enter, and removal during COMPARE
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(9,1,3));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,1,3,0));
    vecs.push_back(idle(0,1,0,0,2));
    vecs.push_back(kd(1,1,2)); vecs.push_back(kd(2,2,2));
    vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,0,3,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,3,0));
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(1,1,3));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,1,3,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,3,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,3,0));
    // rst during COMPARE
    vecs.push_back(idle(0,0,0,0,3));
    vecs.push_back(kd(7,1,3));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,0,1,3,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,0,0,0,3,0));
    vecs.push_back(idle(0,0,0,0,3));

    foreach (vecs[i]) begin
      step(vecs[i].card, vecs[i].kv, vecs[i].d, vecs[i].ke, vecs[i].kc, vecs[i].rs);
      check("pin_correct",   i, int'(pin_correct),   int'(vecs[i].pc));
      check("pin_fail",      i, int'(pin_fail),      int'(vecs[i].pf));
      check("card_retained", i, int'(card_retained), int'(vecs[i].cr));
      check("tries_left",    i, int'(tries_left),    int'(vecs[i].tl));
      check("timeout",       i, int'(timeout),       0);
      if (!vecs[i].cnt_dc)
        check("digit_count", i, int'(digit_count), int'(vecs[i].cnt));
    end

    // Inactivity in ENTRY: fresh reset, insert card, then no keys.
    step(0, 0, 4'd0, 0, 0, 1);
    step(1, 0, 4'd0, 0, 0, 0);
    first_to = -1; to_count = 0; fail_with = 0; tries_at = 0;
`ifdef PIN_TIMEOUT_EN
    for (int i = 1; i <= 25; i++) begin
`else
    for (int i = 1; i <= 1100; i++) begin
`endif
      step(1, 0, 4'd0, 0, 0, 0);
      if (timeout) begin
        to_count++;
        if (first_to < 0) begin
          first_to  = i;
          fail_with = int'(pin_fail);
          tries_at  = int'(tries_left);
        end
      end
    end
`ifdef PIN_TIMEOUT_EN
    check("timeout_cycle",    900, first_to,  20);
    check("timeout_count",    900, to_count,  1);
    check("timeout_pin_fail", 900, fail_with, 1);
    check("timeout_tries",    900, tries_at,  2);
    check("timeout_digits",   900, int'(digit_count), 0);
`else
    check("no_timeout",       900, to_count, 0);
    check("wait_tries",       900, int'(tries_left), 3);
    check("wait_fail",        900, int'(pin_fail), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
